tick_timer_sched: RTL
=====================

// Module: tick_timer_sched
// PURPOSE
//   Shared-prescaler timer scheduler. Derives a 1 Hz square wave and a 1-cycle TICK strobe from PCK.
//   Arbitrates N_CH requesters for per-channel one-shot countdown timers measured in TICKs.
//   Sits between the pixel-clock domain logic (display, blink, timeout FSMs) and the single prescaler,
//   so one divider serves all second-based timing.
// PARAMETERS
//   fPck    25174825  PCK frequency in Hz; prescaler MAX = fPck/2 - 1, TICK period P = 2*(MAX+1) cycles
//   N_CH    4         number of requester channels (>=1)
//   DUR_W   8         width of a duration request in TICKs
// PORTS
//   PCK        in   1           sole clock, all logic on posedge
//   RST        in   1           synchronous, active-high reset
//   REQ_VALID  in   N_CH        per-channel load request
//   REQ_DUR    in   N_CH*DUR_W  duration of channel i at [i*DUR_W +: DUR_W]
//   REQ_READY  out  N_CH        one-hot grant; transfer when VALID & READY
//   BUSY       out  N_CH        channel i counting down
//   DONE       out  N_CH        1-cycle pulse on channel expiry
//   CLK_1HZ    out  1           50% square wave, toggles when prescaler hits MAX
//   TICK       out  1           registered 1-cycle pulse in first cycle CLK_1HZ reads 1
// BEHAVIOUR
//   Reset: count=0, CLK_1HZ=0, TICK=0, BUSY=0, DONE=0, remaining=0, RR pointer=0; REQ_READY=0 in reset.
//   Prescaler: count 0..MAX, wrap to 0 and toggle CLK_1HZ at MAX; width $clog2(MAX+1).
//   TICK fires once per P cycles.
//   Arbiter: eligible = REQ_VALID & ~BUSY. Round-robin starting at pointer.
//     REQ_READY is combinational from eligible and the registered pointer; at most one bit set.
//     On transfer, pointer <= winner+1 (mod N_CH). Pointer holds when there is no transfer.
//   Handshake: VALID may not drop before READY; a busy channel's READY is 0 and its request waits.
//   Load (DUR>0): remaining <= DUR, BUSY=1 from the next cycle.
//   Load (DUR=0): no countdown, BUSY stays 0, DONE pulses the next cycle.
//   Countdown: on TICK each busy channel decrements. When TICK & remaining==1: remaining <= 0,
//     BUSY <= 0, DONE pulses the next cycle (concurrent with BUSY falling).
//   A channel granted in a TICK cycle is not decremented by that TICK.
//   DONE therefore arrives after exactly DUR TICKs following the load cycle.
//   Simultaneous DONE on several channels is legal, since countdowns are independent.
//   A channel expiring this cycle may be re-granted from the cycle BUSY reads 0.
//   RST mid-operation: all timers cancelled immediately, no DONE emitted, prescaler restarts phase 0.
// CONFIGURATION
//   TICK_TIMER_CANCEL_EN defined:
//     - adds input CANCEL [N_CH].
//     - CANCEL[i] on a busy channel clears BUSY and remaining next cycle; no DONE.
//     - CANCEL wins over expiry in the same cycle.
//     - CANCEL on an idle channel is ignored, and the channel is still grantable that cycle.
//   Not defined: no CANCEL port. Timers run to completion or RST only.
// TESTING (fPck=8 -> MAX=3, P=8, N_CH=4, DUR_W=8)
//   Reset: RST 3 cycles -> all outputs 0. After release, CLK_1HZ toggles every 4 cycles, TICK every 8 cycles.
//   Single: ch0 VALID DUR=3 -> READY[0] same cycle, BUSY[0] next cycle.
//     DONE[0] 1 cycle after the 3rd TICK following load; BUSY[0] falls with it.
//   Contention: VALID=4'b1111 DUR=1 each -> READY 0001,0010,0100,1000 on 4 consecutive cycles.
//     Then ch0 and ch2 re-request with pointer=0 -> ch0 first.
//   Edge durations: DUR=0 -> DONE 1 cycle later, BUSY never 1.
//     Grant in a TICK cycle with DUR=1 -> DONE after the next TICK, not that one.
//   Reset mid-count: ch1 busy with remaining=2, assert RST -> BUSY=0, no DONE ever for ch1.
//   Cancel (macro on): CANCEL[2] in the same cycle as the expiring TICK -> no DONE[2], BUSY[2]=0.

Source files
------------

// File: rtl/tick_timer_sched.sv
// Shared 1 Hz prescaler with TICK strobe and N_CH round-robin one-shot countdown timers.
// Optional per-channel CANCEL input is compiled in when TICK_TIMER_CANCEL_EN is defined.
module tick_timer_sched #(
    parameter int unsigned fPck  = 25174825,
    parameter int unsigned N_CH  = 4,
    parameter int unsigned DUR_W = 8
) (
    input  logic                  PCK,
    input  logic                  RST,
    input  logic [N_CH-1:0]       REQ_VALID,
    input  logic [N_CH*DUR_W-1:0] REQ_DUR,
`ifdef TICK_TIMER_CANCEL_EN
    input  logic [N_CH-1:0]       CANCEL,
`endif
    output logic [N_CH-1:0]       REQ_READY,
    output logic [N_CH-1:0]       BUSY,
    output logic [N_CH-1:0]       DONE,
    output logic                  CLK_1HZ,
    output logic                  TICK
);
    localparam int unsigned MAX = fPck / 2 - 1;
    localparam int unsigned CW  = (MAX > 0) ? $clog2(MAX + 1) : 1;
    localparam int unsigned PW  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX);
    localparam logic [PW-1:0] PTR_LAST = PW'(N_CH - 1);

    logic [CW-1:0]    count;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    winner;
    logic [PW-1:0]    idx;
    int unsigned      idx_w;
    logic             found;
    logic [N_CH-1:0]  eligible;
    logic [N_CH-1:0]  grant;
    logic [N_CH-1:0]  cancel_hit;
    logic [DUR_W-1:0] remaining [N_CH];

    // TICK is raised on the same edge that drives CLK_1HZ high.
    always_ff @(posedge PCK) begin
        if (RST) begin
            count   <= '0;
            CLK_1HZ <= 1'b0;
            TICK    <= 1'b0;
        end else begin
            TICK <= 1'b0;
            if (count == CNT_MAX) begin
                count   <= '0;
                CLK_1HZ <= ~CLK_1HZ;
                TICK    <= ~CLK_1HZ;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    always_comb begin
        eligible = REQ_VALID & ~BUSY;
        grant    = '0;
        winner   = ptr;
        found    = 1'b0;
        idx_w    = 0;
        idx      = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            idx_w = 32'(ptr) + k;
            if (idx_w >= N_CH) idx_w = idx_w - N_CH;
            idx = PW'(idx_w);
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = idx;
            end
        end
        if (RST) begin
            grant = '0;
            found = 1'b0;
        end
    end

    assign REQ_READY = grant;

`ifdef TICK_TIMER_CANCEL_EN
    assign cancel_hit = CANCEL & BUSY;
`else
    assign cancel_hit = '0;
`endif

    // Cancel outranks expiry; a grant never coincides with a countdown since only idle channels win.
    always_ff @(posedge PCK) begin
        if (RST) begin
            ptr  <= '0;
            BUSY <= '0;
            DONE <= '0;
            for (int unsigned i = 0; i < N_CH; i++) remaining[i] <= '0;
        end else begin
            if (found) ptr <= (winner == PTR_LAST) ? '0 : winner + PW'(1);
            for (int unsigned i = 0; i < N_CH; i++) begin
                DONE[i] <= 1'b0;
                if (cancel_hit[i]) begin
                    BUSY[i]      <= 1'b0;
                    remaining[i] <= '0;
                end else if (grant[i]) begin
                    if (REQ_DUR[i*DUR_W +: DUR_W] == '0) begin
                        DONE[i] <= 1'b1;
                    end else begin
                        remaining[i] <= REQ_DUR[i*DUR_W +: DUR_W];
                        BUSY[i]      <= 1'b1;
                    end
                end else if (BUSY[i] && TICK) begin
                    if (remaining[i] == DUR_W'(1)) begin
                        remaining[i] <= '0;
                        BUSY[i]      <= 1'b0;
                        DONE[i]      <= 1'b1;
                    end else begin
                        remaining[i] <= remaining[i] - DUR_W'(1);
                    end
                end
            end
        end
    end
endmodule
